// File: rtl/lap_timer_ctrl.sv
// Stopwatch controller: BCD m:ss.d counter with start/stop, four lap slots,
// and a recall mode that shows the stored laps one at a time.
module lap_timer_ctrl #(
  parameter int unsigned TICKS_PER_DSEC = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       toggle_i,
  input  logic       lap_i,
  input  logic       recall_i,
  output logic [3:0] dsec_o,
  output logic [3:0] sec0_o,
  output logic [3:0] sec1_o,
  output logic [3:0] min_o,
  output logic       run_o,
  output logic       recall_o,
  output logic [2:0] lap_cnt_o,
  output logic [1:0] recall_idx_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_RECALL} state_e;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] dsec;
  } bcd_time_t;

  localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_DSEC - 1);
  localparam logic [2:0] LAP_SLOTS = 3'd4;

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [7:0] presc_q, presc_d;
  bcd_time_t  cnt_q, cnt_d;
  logic [2:0] lap_cnt_q, lap_cnt_d;
  logic [1:0] recall_idx_q, recall_idx_d;
  bcd_time_t  lap_buf_q [4];
  logic       lap_we;
  logic       req_tog, req_lap, req_rec;
  bcd_time_t  disp;

  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.dsec != 4'd9) begin
      r.dsec = t.dsec + 4'd1;
    end else begin
      r.dsec = 4'd0;
      if (t.sec0 != 4'd9) begin
        r.sec0 = t.sec0 + 4'd1;
      end else begin
        r.sec0 = 4'd0;
        if (t.sec1 != 4'd5) begin
          r.sec1 = t.sec1 + 4'd1;
        end else begin
          r.sec1 = 4'd0;
          r.min  = (t.min == 4'd9) ? 4'd0 : t.min + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Only the highest-priority request acts; the others are dropped.
  assign req_tog = toggle_i;
  assign req_lap = lap_i & ~toggle_i;
  assign req_rec = recall_i & ~toggle_i & ~lap_i;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    ret_d        = ret_q;
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    lap_cnt_d    = lap_cnt_q;
    recall_idx_d = recall_idx_q;
    lap_we       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_tog) begin
          state_d = S_RUN;
        end else if (req_rec && lap_cnt_q != 3'd0) begin
          state_d      = S_RECALL;
          ret_d        = S_IDLE;
          recall_idx_d = 2'd0;
        end
      end
      S_RUN: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = 8'd0;
          cnt_d   = bcd_inc(cnt_q);
        end else begin
          presc_d = presc_q + 8'd1;
        end
        if (req_tog) begin
          state_d = S_PAUSE;
        end else if (req_lap && lap_cnt_q != LAP_SLOTS) begin
          lap_we    = 1'b1;
          lap_cnt_d = lap_cnt_q + 3'd1;
        end
      end
      S_PAUSE: begin
        if (req_tog) begin
          state_d = S_RUN;
        end else if (req_lap) begin
          state_d   = S_IDLE;
          presc_d   = 8'd0;
          cnt_d     = '0;
          lap_cnt_d = 3'd0;
        end else if (req_rec && lap_cnt_q != 3'd0) begin
          state_d      = S_RECALL;
          ret_d        = S_PAUSE;
          recall_idx_d = 2'd0;
        end
      end
      S_RECALL: begin
        if (req_tog) begin
          state_d      = ret_q;
          recall_idx_d = 2'd0;
        end else if (req_rec) begin
          if (({1'b0, recall_idx_q} + 3'd1) < lap_cnt_q) begin
            recall_idx_d = recall_idx_q + 2'd1;
          end else begin
            state_d      = ret_q;
            recall_idx_d = 2'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      presc_q      <= 8'd0;
      cnt_q        <= '0;
      lap_cnt_q    <= 3'd0;
      recall_idx_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      lap_cnt_q    <= lap_cnt_d;
      recall_idx_q <= recall_idx_d;
    end
  end

  // NOTE: the lap buffer has no reset; lap_cnt alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (lap_we && !rst_i) begin
      lap_buf_q[lap_cnt_q[1:0]] <= cnt_q;
    end
  end

  assign disp         = (state_q == S_RECALL) ? lap_buf_q[recall_idx_q] : cnt_q;
  assign dsec_o       = disp.dsec;
  assign sec0_o       = disp.sec0;
  assign sec1_o       = disp.sec1;
  assign min_o        = disp.min;
  assign run_o        = (state_q == S_RUN);
  assign recall_o     = (state_q == S_RECALL);
  assign lap_cnt_o    = lap_cnt_q;
  assign recall_idx_o = recall_idx_q;

endmodule

// File: tb/tb_lap_timer_ctrl.sv
// Directed bench for lap_timer_ctrl: a tick-count reference model pushes the
// expected display/status into a scoreboard queue that is popped after each edge.
module tb_lap_timer_ctrl;

  localparam int T = 4;

  logic       clk_i = 1'b0;
  logic       rst_i, toggle_i, lap_i, recall_i;
  logic [3:0] dsec_o, sec0_o, sec1_o, min_o;
  logic       run_o, recall_o;
  logic [2:0] lap_cnt_o;
  logic [1:0] recall_idx_o;

  lap_timer_ctrl #(.TICKS_PER_DSEC(T)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .toggle_i     (toggle_i),
    .lap_i        (lap_i),
    .recall_i     (recall_i),
    .dsec_o       (dsec_o),
    .sec0_o       (sec0_o),
    .sec1_o       (sec1_o),
    .min_o        (min_o),
    .run_o        (run_o),
    .recall_o     (recall_o),
    .lap_cnt_o    (lap_cnt_o),
    .recall_idx_o (recall_idx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] disp;
    logic        run;
    logic        rec;
    logic [2:0]  lc;
    logic [1:0]  idx;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference model: time is tracked as the number of clock cycles spent in RUN.
  int m_st;    // 0 idle, 1 run, 2 pause, 3 recall
  int m_ret;
  int ticks;
  int m_lc;
  int m_idx;
  int m_laps[4];

  function automatic logic [15:0] bcd(input int tenths);
    int t;
    t = tenths % 6000;
    return {4'(t / 600), 4'((t % 600) / 100), 4'((t % 100) / 10), 4'(t % 10)};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.disp = (m_st == 3) ? bcd(m_laps[m_idx]) : bcd(ticks / T);
    o.run  = (m_st == 1);
    o.rec  = (m_st == 3);
    o.lc   = 3'(m_lc);
    o.idx  = 2'(m_idx);
    return o;
  endfunction

  function automatic obs_t mk(input logic [15:0] d, input logic r, input logic c,
                              input int lc, input int idx);
    obs_t o;
    o.disp = d;
    o.run  = r;
    o.rec  = c;
    o.lc   = 3'(lc);
    o.idx  = 2'(idx);
    return o;
  endfunction

  task automatic pop_check();
    sb_t  e;
    obs_t act;
    e   = sb_q.pop_front();
    act = {min_o, sec1_o, sec0_o, dsec_o, run_o, recall_o, lap_cnt_o, recall_idx_o};
    total++;
    assert (act === e.exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, act, e.exp);
    end
  endtask

  task automatic check_now(input string tag, input obs_t e);
    sb_q.push_back('{tag, e});
    pop_check();
  endtask

  task automatic model_step(input bit t, input bit l, input bit r);
    case (m_st)
      0: begin
        if (t) m_st = 1;
        else if (!l && r && m_lc > 0) begin m_st = 3; m_ret = 0; m_idx = 0; end
      end
      1: begin
        if (t) m_st = 2;
        else if (l && m_lc < 4) begin m_laps[m_lc] = ticks / T; m_lc++; end
        ticks++;
      end
      2: begin
        if (t) m_st = 1;
        else if (l) begin m_st = 0; ticks = 0; m_lc = 0; end
        else if (r && m_lc > 0) begin m_st = 3; m_ret = 2; m_idx = 0; end
      end
      default: begin
        if (t) begin m_st = m_ret; m_idx = 0; end
        else if (!l && r) begin
          if (m_idx < m_lc - 1) m_idx++;
          else begin m_st = m_ret; m_idx = 0; end
        end
      end
    endcase
  endtask

  task automatic do_step(input bit t, input bit l, input bit r, input bit chk, input string tag);
    model_step(t, l, r);
    if (chk) sb_q.push_back('{tag, model_obs()});
    toggle_i = t;
    lap_i    = l;
    recall_i = r;
    @(posedge clk_i);
    #1;
    toggle_i = 1'b0;
    lap_i    = 1'b0;
    recall_i = 1'b0;
    if (chk) pop_check();
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) do_step(1'b0, 1'b0, 1'b0, (i == n - 1), tag);
  endtask

  task automatic do_reset(input bit t, input bit l, input bit r, input string tag);
    m_st = 0; m_ret = 0; ticks = 0; m_lc = 0; m_idx = 0;
    sb_q.push_back('{tag, model_obs()});
    rst_i    = 1'b1;
    toggle_i = t;
    lap_i    = l;
    recall_i = r;
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    toggle_i = 1'b0;
    lap_i    = 1'b0;
    recall_i = 1'b0;
    pop_check();
  endtask

  initial begin
    rst_i = 1'b0; toggle_i = 1'b0; lap_i = 1'b0; recall_i = 1'b0;
    for (int i = 0; i < 4; i++) m_laps[i] = 0;

    // Reset overrides a simultaneous start request.
    do_reset(1'b1, 1'b0, 1'b1, "reset_override");
    check_now("reset_vals", mk(16'h0000, 1'b0, 1'b0, 0, 0));

    // Start, first tenth after T cycles, first second after 10*T cycles.
    do_step(1'b1, 1'b0, 1'b0, 1'b1, "start");
    idle_steps(T - 1, "pre_first_dsec");
    idle_steps(1, "first_dsec_model");
    check_now("first_dsec", mk(16'h0001, 1'b1, 1'b0, 0, 0));
    idle_steps(36, "one_sec_model");
    check_now("one_sec", mk(16'h0010, 1'b1, 1'b0, 0, 0));

    // Run up to 9:59.9, then wrap to 0:00.0 and keep running.
    idle_steps(23956, "preload_model");
    check_now("preload", mk(16'h9599, 1'b1, 1'b0, 0, 0));
    idle_steps(T, "wrap_model");
    check_now("wrap", mk(16'h0000, 1'b1, 1'b0, 0, 0));

    // Five laps at distinct times; the first lands on a count step, the fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      idle_steps(3 + 2 * i, "lap_gap");
      do_step(1'b0, 1'b1, 1'b0, 1'b1, "lap_pulse");
    end
    check_now("lap_full", mk(bcd(ticks / T), 1'b1, 1'b0, 4, 0));

    // Pause and walk through the four laps; the fourth recall returns to PAUSE.
    do_step(1'b1, 1'b0, 1'b0, 1'b1, "pause");
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall0_model");
    check_now("recall0", mk(16'h0000, 1'b0, 1'b1, 4, 0));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall1_model");
    check_now("recall1", mk(16'h0002, 1'b0, 1'b1, 4, 1));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall2_model");
    check_now("recall2", mk(16'h0004, 1'b0, 1'b1, 4, 2));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall3_model");
    check_now("recall3", mk(16'h0006, 1'b0, 1'b1, 4, 3));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall_exit_model");
    check_now("recall_exit", mk(16'h0010, 1'b0, 1'b0, 4, 0));

    // Lap is ignored in RECALL; toggle leaves immediately.
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall_reenter");
    do_step(1'b0, 1'b1, 1'b0, 1'b1, "recall_lap_ignored");
    do_step(1'b1, 1'b0, 1'b0, 1'b1, "recall_toggle_exit");

    // Clear from PAUSE; recall with no laps in IDLE does nothing.
    do_step(1'b0, 1'b1, 1'b0, 1'b1, "clear_model");
    check_now("clear", mk(16'h0000, 1'b0, 1'b0, 0, 0));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "idle_recall_model");
    check_now("idle_recall_ignored", mk(16'h0000, 1'b0, 1'b0, 0, 0));

    // Toggle+lap together in RUN pauses without storing; prescaler resumes from its held value.
    do_step(1'b1, 1'b0, 1'b0, 1'b1, "restart");
    idle_steps(6, "run6");
    do_step(1'b1, 1'b1, 1'b0, 1'b1, "tog_lap_model");
    check_now("tog_lap", mk(16'h0001, 1'b0, 1'b0, 0, 0));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "pause_recall_empty");
    do_step(1'b1, 1'b0, 1'b0, 1'b1, "resume");
    idle_steps(1, "resume_held_model");
    check_now("resume_held", mk(16'h0002, 1'b1, 1'b0, 0, 0));

    // One lap, recall from PAUSE, single-entry recall returns, then reset during RECALL.
    do_step(1'b0, 1'b1, 1'b0, 1'b1, "lap_one");
    idle_steps(2, "run2");
    do_step(1'b1, 1'b0, 1'b0, 1'b1, "pause2");
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall_one_model");
    check_now("recall_one", mk(16'h0002, 1'b0, 1'b1, 1, 0));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall_one_exit_model");
    check_now("recall_one_exit", mk(16'h0003, 1'b0, 1'b0, 1, 0));
    do_step(1'b0, 1'b0, 1'b1, 1'b1, "recall_again");
    do_reset(1'b0, 1'b0, 1'b1, "reset_in_recall");
    check_now("reset_in_recall_vals", mk(16'h0000, 1'b0, 1'b0, 0, 0));

    // Reset mid-RUN with a simultaneous lap: no step, no lap.
    do_step(1'b1, 1'b0, 1'b0, 1'b1, "run_again");
    idle_steps(T - 1, "run_to_edge");
    do_reset(1'b0, 1'b1, 1'b0, "reset_in_run");
    idle_steps(2, "after_reset_idle");
    check_now("after_reset_idle_vals", mk(16'h0000, 1'b0, 1'b0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
